// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory controller between the I-cache and D-cache.
// A grant is held for a whole transaction and is always followed by one idle cycle.
module cache_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_PRIO_D = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_done,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_load,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_store,
    input  logic              d_done,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_load,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_store,
    output logic              m_done,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_load,
    output logic              grant_i,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    arb_state_t state_reg, state_next;
    logic       rr_reg, rr_next;     // 1: D wins a tie, 0: I wins a tie
    logic       req_i, req_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= ARB_IDLE;
            rr_reg    <= (RESET_PRIO_D != 0);
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
        end
    end

    assign grant_i = (state_reg == ARB_GNT_I);
    assign grant_d = (state_reg == ARB_GNT_D);

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        m_read     = 1'b0;
        m_write    = 1'b0;
        m_addr     = '0;
        m_store    = '0;
        m_done     = 1'b0;
        i_ready    = 1'b0;
        i_load     = '0;
        d_ready    = 1'b0;
        d_load     = '0;

        // Outputs are forced quiet while reset is held, even before the state register clears.
        if (nrst) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (req_i && (!req_d || !rr_reg)) begin
                        state_next = ARB_GNT_I;
                    end else if (req_d) begin
                        state_next = ARB_GNT_D;
                    end
                end
                ARB_GNT_I: begin
                    // A requester that dropped everything is aborting; the bus goes quiet at once.
                    if (req_i || i_done) begin
                        m_read  = i_read;
                        m_addr  = i_addr;
                        m_done  = i_done;
                        i_ready = m_ready;
                        i_load  = m_load;
                    end
                    if (m_ready && i_done) begin
                        state_next = ARB_IDLE;
                        rr_next    = 1'b1;
                    end else if (!req_i) begin
                        state_next = ARB_IDLE;
                    end
                end
                ARB_GNT_D: begin
                    if (req_d || d_done) begin
                        m_read  = d_read;
                        m_write = d_write;
                        m_addr  = d_addr;
                        m_store = d_store;
                        m_done  = d_done;
                        d_ready = m_ready;
                        d_load  = m_load;
                    end
                    if (m_ready && d_done) begin
                        state_next = ARB_IDLE;
                        rr_next    = 1'b0;
                    end else if (!req_d) begin
                        state_next = ARB_IDLE;
                    end
                end
                default: state_next = ARB_IDLE;
            endcase
        end
    end

endmodule
